// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture unit and whoever drives it and reads its results.
// The slave side is the capture unit; the master side drives enable/pwm_in and consumes the results.
interface pwm_capture_if #(
   parameter int WIDTH = 16
);
   logic             enable;
   logic             pwm_in;
   logic [WIDTH-1:0] highTime;
   logic [WIDTH-1:0] period;
   logic             valid;
   logic             overflow;

   modport master (
      output enable,
      output pwm_in,
      input  highTime,
      input  period,
      input  valid,
      input  overflow
   );

   modport slave (
      input  enable,
      input  pwm_in,
      output highTime,
      output period,
      output valid,
      output overflow
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high-phase length and rising-to-rising period of pwm_in in clk cycles.
// Define PWM_CAPTURE_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
module pwm_capture #(
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   pwm_capture_if.slave bus_io
);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } stateT;

   localparam logic [WIDTH-1:0] CountMax = '1;
   localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

   logic             s1Q;
   logic             s2Q;
   logic             levelD;
   logic             levelQ;
   logic             riseQ;
   logic             fallQ;

   stateT            stateQ;
   logic [WIDTH-1:0] countQ;
   logic [WIDTH-1:0] countIncD;
   logic [WIDTH-1:0] pendHighQ;
   logic [WIDTH-1:0] highTimeQ;
   logic [WIDTH-1:0] periodQ;
   logic             validQ;
   logic             overflowQ;

`ifdef PWM_CAPTURE_FILTER_EN
   logic             h0Q;
   logic             h1Q;

   // The accepted level only changes once three consecutive synchronized samples agree.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h0Q <= 1'b0;
         h1Q <= 1'b0;
      end else begin
         h0Q <= s2Q;
         h1Q <= h0Q;
      end
   end

   always_comb begin
      levelD = levelQ;
      if ((s2Q == h0Q) && (h0Q == h1Q)) begin
         levelD = s2Q;
      end
   end
`else
   assign levelD = s2Q;
`endif

   // Edge flags are registered so the state machine acts on a clean one-cycle pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1Q    <= 1'b0;
         s2Q    <= 1'b0;
         levelQ <= 1'b0;
         riseQ  <= 1'b0;
         fallQ  <= 1'b0;
      end else begin
         s1Q    <= bus_io.pwm_in;
         s2Q    <= s1Q;
         levelQ <= levelD;
         riseQ  <= levelD & ~levelQ;
         fallQ  <= ~levelD & levelQ;
      end
   end

   assign countIncD = countQ + CountOne;

   // Saturation is checked before edges: a phase that reaches the limit is never reported.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= IDLE;
         countQ    <= '0;
         pendHighQ <= '0;
         highTimeQ <= '0;
         periodQ   <= '0;
         validQ    <= 1'b0;
         overflowQ <= 1'b0;
      end else begin
         validQ <= 1'b0;
         if (!bus_io.enable) begin
            stateQ <= IDLE;
            countQ <= '0;
         end else begin
            case (stateQ)
               IDLE: begin
                  countQ <= '0;
                  if (riseQ) begin
                     stateQ <= HIGH;
                     countQ <= CountOne;
                  end
               end
               HIGH: begin
                  if (countQ == CountMax) begin
                     overflowQ <= 1'b1;
                     stateQ    <= IDLE;
                     countQ    <= '0;
                  end else begin
                     countQ <= countIncD;
                     if (fallQ) begin
                        pendHighQ <= countQ;
                        stateQ    <= LOW;
                     end
                  end
               end
               LOW: begin
                  if (countQ == CountMax) begin
                     overflowQ <= 1'b1;
                     stateQ    <= IDLE;
                     countQ    <= '0;
                  end else if (riseQ) begin
                     highTimeQ <= pendHighQ;
                     periodQ   <= countQ;
                     validQ    <= 1'b1;
                     overflowQ <= 1'b0;
                     countQ    <= CountOne;
                     stateQ    <= HIGH;
                  end else begin
                     countQ <= countIncD;
                  end
               end
               default: begin
                  stateQ <= IDLE;
                  countQ <= '0;
               end
            endcase
         end
      end
   end

   assign bus_io.highTime = highTimeQ;
   assign bus_io.period   = periodQ;
   assign bus_io.valid    = validQ;
   assign bus_io.overflow = overflowQ;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, bit width of the measurement counter and of the measurement outputs.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port enable  input  1  measurement enable; low forces IDLE.
REQ-005 SHALL provide port pwm_in  input  1  asynchronous PWM signal to be measured.
REQ-006 SHALL provide port highTime  output  WIDTH  last captured high-phase length in clk cycles.
REQ-007 SHALL provide port period  output  WIDTH  last captured rising-to-rising length in clk cycles.
REQ-008 SHALL provide port valid  output  1  one-cycle strobe when highTime/period update.
REQ-009 SHALL provide port overflow  output  1  sticky flag: counter saturated (stuck level or period too long).

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchronizer and detect rising/falling edges on the synchronized level.
REQ-011 SHALL implement states IDLE, HIGH, LOW.
REQ-012 IDLE: counter held 0; on rising edge -> HIGH with counter loaded to 1; falling edges ignored.
REQ-013 HIGH: counter increments each cycle; on falling edge store counter into a pending high register, counter continues, -> LOW.
REQ-014 LOW: counter increments each cycle; on rising edge drive highTime = pending high, period = counter, valid = 1 for one cycle, reload counter to 1, -> HIGH.
REQ-015 For an input high H cycles then low L cycles, captured values SHALL be highTime = H, period = H + L.
REQ-016 valid SHALL assert exactly 3 clk cycles after the first clk edge that samples pwm_in high at the start of the next period.
REQ-017 The first rising edge after IDLE SHALL NOT produce valid; first valid needs one complete period.
REQ-018 Counter SHALL saturate at 2^WIDTH-1; on reaching it in HIGH or LOW: overflow = 1, -> IDLE, no valid, highTime/period unchanged.
REQ-019 overflow SHALL stay set until the next valid strobe, which clears it in the same cycle valid asserts.
REQ-020 enable low SHALL force IDLE next cycle, suppress valid, hold highTime/period/overflow.
REQ-021 highTime/period SHALL hold last captured values between strobes.

Reset
REQ-022 rst low SHALL asynchronously set state IDLE, counter 0, synchronizer flops 0, highTime 0, period 0, valid 0, overflow 0.
REQ-023 rst release SHALL take effect on the next clk edge; a reset mid-period discards the partial measurement.

Configuration
REQ-024 Macro PWM_CAPTURE_FILTER_EN SHALL, when defined, insert a glitch filter after the synchronizer: level accepted only after 3 consecutive equal samples.
REQ-025 With PWM_CAPTURE_FILTER_EN defined, pulses/gaps shorter than 3 cycles SHALL be ignored and REQ-016 latency SHALL become 5 cycles; H, L >= 3 still measure exactly.
REQ-026 Without PWM_CAPTURE_FILTER_EN, no filter logic SHALL exist and every synchronized edge SHALL be acted on.

Verification
REQ-027 WIDTH=8, enable=1, pwm_in 3 high / 7 low repeated -> from second period on, valid every 10 cycles, highTime=3, period=10, overflow=0.
REQ-028 WIDTH=8, pwm_in held high 300 cycles -> overflow=1 at saturation (255), no valid, highTime/period unchanged; then 5/5 waveform -> valid with highTime=5, period=10, overflow cleared.
REQ-029 Steady 4/6 waveform, drop enable mid-LOW for 2 cycles, re-enable -> no valid for the interrupted period; next complete period gives highTime=4, period=10.
REQ-030 Assert rst during HIGH of 6/4 waveform -> all outputs 0 immediately; after release first valid only after a full period, values 6/10.
REQ-031 With PWM_CAPTURE_FILTER_EN, 8/8 waveform with a 1-cycle low glitch in the high phase -> highTime=8, period=16; without macro the same stimulus yields a shortened highTime.
